// File: rtl/mbist_controller_if.sv
// SRAM-side bus of the MBIST engine: address, write data, strobes
// and the read data returned by the memory.
interface mbist_controller_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ADDR_top;
  logic [DATA_W-1:0] DATAOUT;
  logic              iWrite;
  logic              iRead;
  logic [DATA_W-1:0] DATA_DUT;

  modport master (
    output ADDR_top,
    output DATAOUT,
    output iWrite,
    output iRead,
    input  DATA_DUT
  );

  modport slave (
    input  ADDR_top,
    input  DATAOUT,
    input  iWrite,
    input  iRead,
    output DATA_DUT
  );
endinterface

// File: rtl/mbist_controller.sv
// March / checkerboard BIST engine for a single-port SRAM:
// MATS+, March C- and checkerboard, sticky mismatch flag.
module mbist_controller #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       MBISTEN,
  input  logic [2:0] TESTTYPE,
  output logic [3:0] gen_Turn,
  output logic       RESULT,
  mbist_controller_if.master sram
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_CMP,
    S_DONE
  } st_t;

  localparam logic [1:0] M_MATS = 2'd0;
  localparam logic [1:0] M_MC   = 2'd1;
  localparam logic [1:0] M_CB   = 2'd2;
  localparam logic [ADDR_W-1:0] ONE = 1;

  st_t               st, nxt_st;
  logic [1:0]        mode, nxt_mode, sel;
  logic [2:0]        elem, nxt_elem;
  logic [ADDR_W-1:0] addr, nxt_addr, end_addr;
  logic              opi, nxt_opi, issue;

  logic              wr_d, rd_d, run_d, res_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic [3:0]        turn_d;

  // Element tables: op is a read?
  function automatic logic f_rd(input logic [1:0] m,
                                input logic [2:0] e,
                                input logic       o);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (m == M_CB): r = (e == 3'd1) || (e == 3'd3);
      (m == M_MC): r = (e == 3'd5) || ((e != 3'd0) && !o);
      default:     r = (e != 3'd0) && !o;
    endcase
    return r;
  endfunction

  // Background select: 0/1 for march, P/~P for checkerboard
  function automatic logic f_val(input logic [1:0] m,
                                 input logic [2:0] e,
                                 input logic       o);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (m == M_CB): r = (e == 3'd2) || (e == 3'd3);
      (m == M_MC): begin
        if ((e == 3'd1) || (e == 3'd3))      r = o;
        else if ((e == 3'd2) || (e == 3'd4)) r = !o;
      end
      default: begin
        if (e == 3'd1)      r = o;
        else if (e == 3'd2) r = !o;
      end
    endcase
    return r;
  endfunction

  function automatic logic f_two(input logic [1:0] m,
                                 input logic [2:0] e);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (m == M_CB): r = 1'b0;
      (m == M_MC): r = (e != 3'd0) && (e != 3'd5);
      default:     r = (e != 3'd0);
    endcase
    return r;
  endfunction

  function automatic logic f_down(input logic [1:0] m,
                                  input logic [2:0] e);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (m == M_CB): r = 1'b0;
      (m == M_MC): r = (e == 3'd3) || (e == 3'd4);
      default:     r = (e == 3'd2);
    endcase
    return r;
  endfunction

  function automatic logic [2:0] f_last(input logic [1:0] m);
    logic [2:0] r;
    r = 3'd2;
    unique case (1'b1)
      (m == M_CB): r = 3'd3;
      (m == M_MC): r = 3'd5;
      default:     r = 3'd2;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] pat(input logic cb,
                                            input logic v,
                                            input logic a0);
    logic [DATA_W-1:0] p;
    p = a0 ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}};
    if (cb) return v ? ~p : p;
    return {DATA_W{v}};
  endfunction

  assign sel = (TESTTYPE == 3'd1) ? M_MC :
               (TESTTYPE == 3'd2) ? M_CB : M_MATS;

  assign end_addr = f_down(mode, elem) ? '0 : '1;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      st            <= S_IDLE;
      mode          <= M_MATS;
      elem          <= '0;
      addr          <= '0;
      opi           <= 1'b0;
      sram.iWrite   <= 1'b0;
      sram.iRead    <= 1'b0;
      sram.ADDR_top <= '0;
      sram.DATAOUT  <= '0;
      gen_Turn      <= '0;
      RESULT        <= 1'b0;
    end else begin
      st            <= nxt_st;
      mode          <= nxt_mode;
      elem          <= nxt_elem;
      addr          <= nxt_addr;
      opi           <= nxt_opi;
      sram.iWrite   <= wr_d;
      sram.iRead    <= rd_d;
      sram.ADDR_top <= addr_d;
      sram.DATAOUT  <= data_d;
      gen_Turn      <= turn_d;
      RESULT        <= res_d;
    end
  end

  always_comb begin
    nxt_st   = st;
    nxt_mode = mode;
    nxt_elem = elem;
    nxt_addr = addr;
    nxt_opi  = opi;
    issue    = 1'b0;
    if (!MBISTEN) begin
      nxt_st   = S_IDLE;
      nxt_elem = '0;
      nxt_addr = '0;
      nxt_opi  = 1'b0;
    end else begin
      unique case (st)
        S_IDLE: begin
          nxt_mode = sel;
          nxt_elem = '0;
          nxt_opi  = 1'b0;
          nxt_addr = f_down(sel, 3'd0) ? '1 : '0;
          issue    = 1'b1;
        end
        S_RD_ISSUE: nxt_st = S_RD_CMP;
        S_WR, S_RD_CMP: begin
          issue = 1'b1;
          if (!opi && f_two(mode, elem)) begin
            nxt_opi = 1'b1;
          end else begin
            nxt_opi = 1'b0;
            if (addr != end_addr) begin
              nxt_addr = f_down(mode, elem) ? addr - ONE
                                            : addr + ONE;
            end else if (elem == f_last(mode)) begin
              nxt_st = S_DONE;
              issue  = 1'b0;
            end else begin
              nxt_elem = elem + 3'd1;
              nxt_addr = f_down(mode, elem + 3'd1) ? '1 : '0;
            end
          end
        end
        default: nxt_st = S_DONE;
      endcase
      if (issue)
        nxt_st = f_rd(nxt_mode, nxt_elem, nxt_opi) ? S_RD_ISSUE
                                                   : S_WR;
    end
  end

  always_comb begin
    run_d  = (nxt_st == S_WR) || (nxt_st == S_RD_ISSUE) ||
             (nxt_st == S_RD_CMP);
    wr_d   = (nxt_st == S_WR);
    rd_d   = (nxt_st == S_RD_ISSUE);
    addr_d = run_d ? nxt_addr : '0;
    data_d = '0;
    if (wr_d)
      data_d = pat(nxt_mode == M_CB,
                   f_val(nxt_mode, nxt_elem, nxt_opi),
                   nxt_addr[0]);
    turn_d = 4'h0;
    if (nxt_st == S_DONE) turn_d = 4'hF;
    else if (run_d)       turn_d = {1'b0, nxt_elem};
    res_d = RESULT;
    if ((st == S_IDLE) && MBISTEN)
      res_d = 1'b0;
    else if ((st == S_RD_CMP) && MBISTEN &&
             (sram.DATA_DUT != pat(mode == M_CB,
                                   f_val(mode, elem, opi),
                                   addr[0])))
      res_d = 1'b1;
  end

endmodule

// File: tb/tb_mbist_controller.sv
// Bench for mbist_controller: SRAM model with stuck-at fault
// injection and an op-list reference built from the algorithms.
module tb_mbist_controller;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       MBISTEN;
  logic [2:0] TESTTYPE;
  logic [3:0] gen_Turn;
  logic       RESULT;

  mbist_controller_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mbist_controller #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .MBISTEN  (MBISTEN),
    .TESTTYPE (TESTTYPE),
    .gen_Turn (gen_Turn),
    .RESULT   (RESULT),
    .sram     (bus)
  );

  always #5 CLK = ~CLK;

  logic [7:0] ram [256];
  logic [7:0] rdata;
  logic [7:0] f_or, f_and, f_addr;

  assign bus.DATA_DUT = rdata;

  // Memory with one optional stuck bit seen on read
  always @(posedge CLK) begin
    if (bus.iWrite) ram[bus.ADDR_top] <= bus.DATAOUT;
    if (bus.iRead)
      rdata <= (bus.ADDR_top == f_addr)
               ? ((ram[bus.ADDR_top] | f_or) & ~f_and)
               : ram[bus.ADDR_top];
  end

  typedef struct {
    bit       rd;
    bit [7:0] a;
    bit [7:0] d;
    int       e;
  } op_s;

  op_s q[$];
  int  eidx;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Op kinds: 0 w0, 1 w1, 2 r0, 3 r1, 4 wP, 5 rP, 6 w~P, 7 r~P
  function automatic bit [7:0] kdata(input int k, input int a);
    bit [7:0] p;
    p = (a % 2 == 0) ? 8'h55 : 8'hAA;
    if (k >= 4) return (k >= 6) ? ~p : p;
    return (k % 2 == 1) ? 8'hFF : 8'h00;
  endfunction

  task automatic add_elem(input bit down, input int k0, input int k1);
    for (int i = 0; i < 256; i++) begin
      int a;
      op_s o;
      a = down ? 255 - i : i;
      o.a = 8'(a);
      o.e = eidx;
      o.rd = (k0 == 2 || k0 == 3 || k0 == 5 || k0 == 7);
      o.d = kdata(k0, a);
      q.push_back(o);
      if (k1 >= 0) begin
        o.rd = (k1 == 2 || k1 == 3);
        o.d = kdata(k1, a);
        q.push_back(o);
      end
    end
    eidx++;
  endtask

  task automatic build(input logic [2:0] tt);
    q.delete();
    eidx = 0;
    if (tt == 3'd1) begin
      add_elem(0, 0, -1); add_elem(0, 2, 1); add_elem(0, 3, 0);
      add_elem(1, 2, 1);  add_elem(1, 3, 0); add_elem(0, 2, -1);
    end else if (tt == 3'd2) begin
      add_elem(0, 4, -1); add_elem(0, 5, -1);
      add_elem(0, 6, -1); add_elem(0, 7, -1);
    end else begin
      add_elem(0, 0, -1); add_elem(0, 2, 1); add_elem(1, 3, 0);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Runs one test; abort_at >= 0 drops MBISTEN at that op
  task automatic run_test(input logic [2:0] tt, input int abort_at);
    bit exp_res;
    int f0;
    build(tt);
    exp_res = 0;
    f0 = n_fail;
    TESTTYPE = tt;
    MBISTEN = 1'b1;
    step();
    for (int i = 0; i < q.size(); i++) begin
      if (n_fail - f0 > 8) begin
        MBISTEN = 1'b0;
        step(); step();
        return;
      end
      if (i == abort_at) begin
        MBISTEN = 1'b0;
        step();
        chk("abort_idle",
            {bus.iWrite, bus.iRead, bus.ADDR_top, bus.DATAOUT,
             gen_Turn, RESULT},
            {1'b0, 1'b0, 8'h00, 8'h00, 4'h0, exp_res});
        return;
      end
      if (i == 3) TESTTYPE = ~tt;
      if (!q[i].rd) begin
        chk("write_op",
            {bus.iWrite, bus.iRead, bus.ADDR_top, bus.DATAOUT,
             gen_Turn, RESULT},
            {1'b1, 1'b0, q[i].a, q[i].d, 4'(q[i].e), exp_res});
        step();
      end else begin
        chk("read_issue",
            {bus.iWrite, bus.iRead, bus.ADDR_top, gen_Turn, RESULT},
            {1'b0, 1'b1, q[i].a, 4'(q[i].e), exp_res});
        step();
        chk("read_cmp",
            {bus.iWrite, bus.iRead, gen_Turn, RESULT},
            {1'b0, 1'b0, 4'(q[i].e), exp_res});
        step();
        if (q[i].a == f_addr &&
            (((q[i].d | f_or) & ~f_and) != q[i].d))
          exp_res = 1;
      end
    end
    chk("done", {bus.iWrite, bus.iRead, gen_Turn, RESULT},
        {1'b0, 1'b0, 4'hF, exp_res});
    step(); step(); step();
    chk("done_hold", {bus.iWrite, bus.iRead, gen_Turn, RESULT},
        {1'b0, 1'b0, 4'hF, exp_res});
    MBISTEN = 1'b0;
    step();
    chk("idle_after_done",
        {bus.iWrite, bus.iRead, bus.ADDR_top, bus.DATAOUT,
         gen_Turn, RESULT},
        {1'b0, 1'b0, 8'h00, 8'h00, 4'h0, exp_res});
    step();
    chk("idle_keep_result", {gen_Turn, RESULT}, {4'h0, exp_res});
  endtask

  task automatic set_fault(input int kind, input int a,
                           input int b);
    f_addr = 8'(a);
    f_or = 8'h00;
    f_and = 8'h00;
    if (kind == 1) f_and = 8'(1 << b);
    if (kind == 2) f_or = 8'(1 << b);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    rdata = 8'h00;
    set_fault(0, 0, 0);
    nRESET = 1'b0;
    MBISTEN = 1'b0;
    TESTTYPE = 3'd0;
    repeat (50) @(posedge CLK);
    #1;
    chk("reset",
        {bus.iWrite, bus.iRead, bus.ADDR_top, bus.DATAOUT,
         gen_Turn, RESULT}, 32'h0);
    nRESET = 1'b1;
    step();

    run_test(3'd0, -1);
    set_fault(2, 8'h2A, 3);
    run_test(3'd1, -1);
    set_fault(0, 0, 0);
    run_test(3'd2, -1);

    run_test(3'd0, 100);
    run_test(3'd0, -1);

    for (int r = 0; r < 5; r++) begin
      set_fault($urandom_range(0, 2), $urandom_range(0, 255),
                $urandom_range(0, 7));
      run_test(3'($urandom_range(0, 7)), -1);
    end

    set_fault(0, 0, 0);
    TESTTYPE = 3'd2;
    MBISTEN = 1'b1;
    repeat (30) @(posedge CLK);
    #3;
    nRESET = 1'b0;
    #1;
    chk("async_reset",
        {bus.iWrite, bus.iRead, bus.ADDR_top, bus.DATAOUT,
         gen_Turn, RESULT}, 32'h0);
    MBISTEN = 1'b0;
    step();
    nRESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_quiet",
          {bus.iWrite, bus.iRead, gen_Turn}, 32'h0);
    end
    set_fault(1, $urandom_range(0, 255), $urandom_range(0, 7));
    run_test(3'd1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
